// File: rtl/reg_bank_reader.sv
// reg_bank_reader: read-side sequencer for the signed amplitude register bank.
// After an accepted start it walks addresses 0..len-1 (len clamped to DEPTH).
// Each word goes out on a valid/ready stream, and the final beat is flagged.
// The bank read port has a one-cycle latency. Every output is registered.
//
// Stream handshake: a beat transfers on a rising edge where m_valid && m_ready.
// Once m_valid is high, m_data and m_last stay stable until that transfer.
// m_valid is never withdrawn without a transfer.
//
// Optional feature: define REG_READER_BITREV_EN to add the bitrev input.
// When it is latched high and the readout covers the whole bank, the bank is
// read in bit-reversed address order (QFT output ordering).
module reg_bank_reader #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
`ifdef REG_READER_BITREV_EN
    input  logic              bitrev,
`endif
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    localparam int LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, READ, CAPT, HOLD} state_t;

    state_t            state, state_d;
    logic [LEN_W-1:0]  cnt, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              rd_en_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic [DATA_W-1:0] m_data_d;
    logic              m_valid_d, m_last_d, done_d;
    logic [LEN_W-1:0]  next_cnt;
    logic [ADDR_W-1:0] next_addr;
`ifdef REG_READER_BITREV_EN
    logic              bitrev_q, bitrev_d;
`endif

    function automatic logic [ADDR_W-1:0] bit_rev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
        return r;
    endfunction

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Address of the next beat: linear by default, bit-reversed only for full-bank readouts.
    always_comb begin
        next_cnt  = cnt + LEN_W'(1);
        next_addr = next_cnt[ADDR_W-1:0];
`ifdef REG_READER_BITREV_EN
        if (bitrev_q && (len_q == LEN_W'(DEPTH))) next_addr = bit_rev(next_cnt[ADDR_W-1:0]);
`endif
    end

    // Next-state and next-output decode; everything holds unless a transition changes it.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        len_d     = len_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr;
        m_data_d  = m_data;
        m_valid_d = m_valid;
        m_last_d  = m_last;
        done_d    = 1'b0;
`ifdef REG_READER_BITREV_EN
        bitrev_d  = bitrev_q;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        len_d     = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
                        cnt_d     = '0;
                        rd_en_d   = 1'b1;
                        rd_addr_d = '0;  // address 0 is its own bit-reverse
                        state_d   = READ;
`ifdef REG_READER_BITREV_EN
                        bitrev_d  = bitrev;
`endif
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: state_d = CAPT;
            CAPT: begin
                m_data_d  = rd_data;
                m_valid_d = 1'b1;
                m_last_d  = (cnt == len_q - LEN_W'(1));
                state_d   = HOLD;
            end
            HOLD: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (m_last) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d     = next_cnt;
                        rd_en_d   = 1'b1;
                        rd_addr_d = next_addr;
                        state_d   = READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs; reset aborts any readout without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            len_q    <= '0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            m_data   <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            done     <= 1'b0;
`ifdef REG_READER_BITREV_EN
            bitrev_q <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            len_q    <= len_d;
            rd_en    <= rd_en_d;
            rd_addr  <= rd_addr_d;
            m_data   <= m_data_d;
            m_valid  <= m_valid_d;
            m_last   <= m_last_d;
            done     <= done_d;
`ifdef REG_READER_BITREV_EN
            bitrev_q <= bitrev_d;
`endif
        end
    end

endmodule
